uart_core_sys: RTL and testbench
================================

// Module: uart_core_sys
// PURPOSE
//  Full-duplex UART with host-side FIFOs: baud tick generator, oversampling RX, TX serializer.
//  Host pushes bytes into TX FIFO and pops received bytes from RX FIFO.
//  Sits between the FPGA pins (rx/tx) and on-chip host logic. Frame: 8N1, LSB first, idle high.
// PARAMETERS
//  WIDTH          8            data bits per frame / FIFO word width
//  CLOCK_HZ       100_000_000  clk frequency (Hz)
//  BAUD           115_200      line rate (bit/s)
//  OVERSAMPLE     16           baud ticks per bit (even, >=4)
//  TX_FIFO_DEPTH  16           TX FIFO entries (power of 2)
//  RX_FIFO_DEPTH  16           RX FIFO entries (power of 2)
// PORTS
//  clk             in   1      system clock
//  reset           in   1      asynchronous, active-low reset (0 = reset)
//  rx              in   1      serial input (asynchronous to clk)
//  tx              out  1      serial output
//  read_uart       in   1      pop one byte from RX FIFO
//  read_data       out  WIDTH  popped RX byte (registered)
//  rx_empty        out  1      RX FIFO empty
//  rx_full         out  1      RX FIFO full
//  write_data      in   WIDTH  byte to push into TX FIFO
//  write_uart      in   1      push write_data into TX FIFO
//  tx_full         out  1      TX FIFO full
//  rx_frame_error  out  1      1-cycle pulse: stop bit sampled low
// BEHAVIOUR
//  Reset (reset=0, async): tx=1, read_data=0, rx_empty=1, rx_full=0, tx_full=0, rx_frame_error=0;
//   FIFOs emptied, RX/TX FSMs to IDLE, tick counter cleared.
//  Tick: DIV = CLOCK_HZ/(BAUD*OVERSAMPLE) (integer); 1-cycle tick every DIV clocks, free-running.
//   Bit period = DIV*OVERSAMPLE clocks, shared by RX and TX.
//  RX sync: rx through 2-FF synchronizer (reset value 1) before the FSM.
//  RX FSM IDLE->START->DATA->STOP->IDLE, counting ticks:
//   IDLE: synced rx=0 -> START, clear tick count.
//   START: at OVERSAMPLE/2 ticks re-check rx; 0 -> DATA, 1 -> IDLE (glitch, no output).
//   DATA: every OVERSAMPLE ticks sample one bit, shift in LSB first; after WIDTH bits -> STOP.
//   STOP: after OVERSAMPLE ticks sample; 1 -> push byte to RX FIFO; 0 -> pulse rx_frame_error
//    exactly 1 clk, byte discarded. Both -> IDLE.
//   RX FIFO full at push: byte dropped, FIFO contents unchanged, no error flag.
//  TX FSM IDLE->START->DATA->STOP->IDLE:
//   IDLE (tx=1): TX FIFO non-empty -> pop head, -> START.
//   START tx=0, DATA tx=bit[i] LSB first, STOP tx=1; each state bit held OVERSAMPLE ticks.
//   After STOP, next queued byte starts immediately (back-to-back frames, no extra idle).
//  TX FIFO: push on posedge with write_uart=1 & tx_full=0; write_uart while full ignored.
//  RX FIFO: pop on posedge with read_uart=1 & rx_empty=0; read_data updated that same edge and
//   held until next pop; read_uart while empty ignored, read_data unchanged.
//  FIFOs: circular, pointer wrap at depth; full/empty flags registered, exact (depth entries usable).
//   Simultaneous push+pop: when full, the pop proceeds and the push is blocked (full sampled);
//   when empty, the pop is ignored and the push completes; otherwise both occur, count unchanged.
//  Reset mid-frame: frame aborted, tx returns to 1 asynchronously, partial RX byte lost.
// TESTING (scaled: CLOCK_HZ=1e6, BAUD=9600, OVERSAMPLE=4 -> DIV=26, bit=104 clk)
//  Reset: hold reset=0 5 clk -> tx=1, rx_empty=1, tx_full=0, rx_full=0, rx_frame_error=0.
//  Loopback rx=tx, write 8'h55, 8'hA3, 8'h00 -> reads return 55, A3, 00 in order; then rx_empty=1.
//  Bit-bang C1 with stop=0 on rx -> rx_frame_error high 1 clk within 2000 clk; rx_empty stays 1.
//  Write 17 bytes quickly with tx stalled-free check: tx_full=1 after 16 queued beyond head; extra
//   write ignored; all accepted bytes appear on tx in order.
//  Inject 17 good frames without reading -> rx_full=1; 16 bytes read back in order, 17th dropped.
//  Start glitch (rx low < bit/2) -> no byte, no frame error; read on empty FIFO -> read_data unchanged.

Source files
------------

// File: rtl/uart_core_sys.sv
// uart_core_sys: full-duplex 8N1 UART with host-side TX and RX FIFOs
// Ports: clk; reset (async, active-low); rx/tx serial pins, idle high;
//   write_uart/write_data/tx_full form the TX FIFO push side;
//   read_uart/read_data/rx_empty/rx_full form the RX FIFO pop side (read_data registered);
//   rx_frame_error pulses for one clk when a stop bit is sampled low.
module uart_core_sys #(
  parameter int WIDTH         = 8,
  parameter int CLOCK_HZ      = 100_000_000,
  parameter int BAUD          = 115_200,
  parameter int OVERSAMPLE    = 16,
  parameter int TX_FIFO_DEPTH = 16,
  parameter int RX_FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  output logic             tx,
  input  logic             read_uart,
  output logic [WIDTH-1:0] read_data,
  output logic             rx_empty,
  output logic             rx_full,
  input  logic [WIDTH-1:0] write_data,
  input  logic             write_uart,
  output logic             tx_full,
  output logic             rx_frame_error
);
  localparam int DIV = CLOCK_HZ / (BAUD * OVERSAMPLE);
  localparam int TW  = DIV > 1 ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int NW  = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam int TAW = $clog2(TX_FIFO_DEPTH);
  localparam int RAW = $clog2(RX_FIFO_DEPTH);
  localparam int TCW = TAW + 1;
  localparam int RCW = RAW + 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic tick;
  logic [1:0] sync_q, sync_d;
  logic rx_s;
  state_t rx_state_q, rx_state_d, tx_state_q, tx_state_d;
  logic [SW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [NW-1:0] rx_bit_q, rx_bit_d, tx_bit_q, tx_bit_d;
  logic [WIDTH-1:0] rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d;
  logic rx_half, rx_last, rx_push, frame_err_q, frame_err_d;
  logic tx_last, tx_pop, tx_q, tx_d;
  logic [WIDTH-1:0] txf_mem_q [TX_FIFO_DEPTH];
  logic [WIDTH-1:0] rxf_mem_q [RX_FIFO_DEPTH];
  logic [TAW-1:0] txf_wp_q, txf_wp_d, txf_rp_q, txf_rp_d;
  logic [RAW-1:0] rxf_wp_q, rxf_wp_d, rxf_rp_q, rxf_rp_d;
  logic [TCW-1:0] txf_cnt_q, txf_cnt_d;
  logic [RCW-1:0] rxf_cnt_q, rxf_cnt_d;
  logic txf_full_q, txf_full_d, txf_empty_q, txf_empty_d, txf_push;
  logic rxf_full_q, rxf_full_d, rxf_empty_q, rxf_empty_d, rxf_push, rxf_pop;
  logic [WIDTH-1:0] read_data_q, read_data_d;
  assign tx             = tx_q;
  assign read_data      = read_data_q;
  assign rx_empty       = rxf_empty_q;
  assign rx_full        = rxf_full_q;
  assign tx_full        = txf_full_q;
  assign rx_frame_error = frame_err_q;
  assign rx_s           = sync_q[1];
  always_comb begin
    tick = tick_cnt_q == TW'(DIV - 1);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    sync_d = {sync_q[0], rx};
  end
  // RX: half-bit check of the start bit, then one sample per bit period near mid-bit.
  assign rx_half = tick & (rx_state_q == START) & (rx_cnt_q == SW'(OVERSAMPLE / 2 - 1));
  assign rx_last = tick & (rx_cnt_q == SW'(OVERSAMPLE - 1));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rx_state_q  <= IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_sh_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_sh_q     <= rx_sh_d;
      frame_err_q <= frame_err_d;
    end
  always_comb begin
    rx_state_d = rx_state_q;
    rx_sh_d = rx_sh_q;
    rx_cnt_d = (rx_state_q == IDLE || rx_half || rx_last) ? '0 : rx_cnt_q + SW'(tick);
    rx_bit_d = rx_state_q != DATA ? '0 : rx_bit_q + NW'(rx_last);
    case (rx_state_q)
      IDLE:  rx_state_d = rx_s ? IDLE : START;
      START: if (rx_half) rx_state_d = rx_s ? IDLE : DATA;
      DATA:  if (rx_last) begin
        rx_sh_d = {rx_s, rx_sh_q[WIDTH-1:1]};
        if (rx_bit_q == NW'(WIDTH - 1)) rx_state_d = STOP;
      end
      default: if (rx_last) rx_state_d = IDLE;
    endcase
  end
  always_comb begin
    rx_push = (rx_state_q == STOP) & rx_last & rx_s;
    frame_err_d = (rx_state_q == STOP) & rx_last & ~rx_s;
  end
  // TX: frames start on a tick so every bit lasts exactly OVERSAMPLE ticks; the
  // next queued byte is popped on the final stop-bit tick for back-to-back frames.
  assign tx_last = tick & (tx_cnt_q == SW'(OVERSAMPLE - 1));
  assign tx_pop  = tick & ~txf_empty_q & ((tx_state_q == IDLE) | ((tx_state_q == STOP) & tx_last));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_q       <= tx_d;
    end
  always_comb begin
    tx_state_d = tx_state_q;
    tx_sh_d = tx_sh_q;
    tx_cnt_d = (tx_state_q == IDLE || tx_last) ? '0 : tx_cnt_q + SW'(tick);
    tx_bit_d = tx_state_q != DATA ? '0 : tx_bit_q + NW'(tx_last);
    case (tx_state_q)
      IDLE:  if (tx_pop) begin
        tx_state_d = START;
        tx_sh_d = txf_mem_q[txf_rp_q];
      end
      START: if (tx_last) tx_state_d = DATA;
      DATA:  if (tx_last) begin
        tx_sh_d = tx_sh_q >> 1;
        if (tx_bit_q == NW'(WIDTH - 1)) tx_state_d = STOP;
      end
      default: if (tx_pop) begin
        tx_state_d = START;
        tx_sh_d = txf_mem_q[txf_rp_q];
      end else if (tx_last) tx_state_d = IDLE;
    endcase
  end
  always_comb tx_d = tx_state_d == START ? 1'b0 : tx_state_d == DATA ? tx_sh_d[0] : 1'b1;
  // FIFOs: flags come from the sampled count, so a push into a full FIFO is
  // blocked even when a pop happens on the same edge.
  always_comb begin
    txf_push = write_uart & ~txf_full_q;
    txf_wp_d = txf_wp_q + TAW'(txf_push);
    txf_rp_d = txf_rp_q + TAW'(tx_pop);
    txf_cnt_d = txf_cnt_q + TCW'(txf_push) - TCW'(tx_pop);
    txf_full_d = txf_cnt_d == TCW'(TX_FIFO_DEPTH);
    txf_empty_d = txf_cnt_d == '0;
    rxf_push = rx_push & ~rxf_full_q;
    rxf_pop = read_uart & ~rxf_empty_q;
    rxf_wp_d = rxf_wp_q + RAW'(rxf_push);
    rxf_rp_d = rxf_rp_q + RAW'(rxf_pop);
    rxf_cnt_d = rxf_cnt_q + RCW'(rxf_push) - RCW'(rxf_pop);
    rxf_full_d = rxf_cnt_d == RCW'(RX_FIFO_DEPTH);
    rxf_empty_d = rxf_cnt_d == '0;
    read_data_d = rxf_pop ? rxf_mem_q[rxf_rp_q] : read_data_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tick_cnt_q  <= '0;
      sync_q      <= '1;
      txf_wp_q    <= '0;
      txf_rp_q    <= '0;
      txf_cnt_q   <= '0;
      txf_full_q  <= 1'b0;
      txf_empty_q <= 1'b1;
      rxf_wp_q    <= '0;
      rxf_rp_q    <= '0;
      rxf_cnt_q   <= '0;
      rxf_full_q  <= 1'b0;
      rxf_empty_q <= 1'b1;
      read_data_q <= '0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      sync_q      <= sync_d;
      txf_wp_q    <= txf_wp_d;
      txf_rp_q    <= txf_rp_d;
      txf_cnt_q   <= txf_cnt_d;
      txf_full_q  <= txf_full_d;
      txf_empty_q <= txf_empty_d;
      rxf_wp_q    <= rxf_wp_d;
      rxf_rp_q    <= rxf_rp_d;
      rxf_cnt_q   <= rxf_cnt_d;
      rxf_full_q  <= rxf_full_d;
      rxf_empty_q <= rxf_empty_d;
      read_data_q <= read_data_d;
    end
  always_ff @(posedge clk) begin
    if (txf_push) txf_mem_q[txf_wp_q] <= write_data;
    if (rxf_push) rxf_mem_q[rxf_wp_q] <= rx_sh_q;
  end
endmodule

// File: tb/tb_uart_core_sys.sv
// tb_uart_core_sys: directed self-checking bench for uart_core_sys (DIV=26, 104 clk per bit)
module tb_uart_core_sys;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx_drv = 1'b1;
  logic loop = 1'b0;
  logic read_uart = 1'b0;
  logic write_uart = 1'b0;
  logic [7:0] write_data = 8'h00;
  logic rx, tx, rx_empty, rx_full, tx_full, rx_frame_error;
  logic [7:0] read_data;
  int tests = 0;
  int fails = 0;
  assign rx = loop ? tx : rx_drv;
  uart_core_sys #(
    .WIDTH(8), .CLOCK_HZ(1_000_000), .BAUD(9600), .OVERSAMPLE(4),
    .TX_FIFO_DEPTH(16), .RX_FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .tx(tx),
    .read_uart(read_uart), .read_data(read_data), .rx_empty(rx_empty), .rx_full(rx_full),
    .write_data(write_data), .write_uart(write_uart), .tx_full(tx_full),
    .rx_frame_error(rx_frame_error)
  );
  always #5 clk = ~clk;
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic push(input logic [7:0] d);
    write_data = d;
    write_uart = 1'b1;
    @(negedge clk);
    write_uart = 1'b0;
  endtask
  task automatic pop();
    read_uart = 1'b1;
    @(negedge clk);
    read_uart = 1'b0;
  endtask
  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    rx_drv = 1'b0;
    wait_clks(104);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      wait_clks(104);
    end
    rx_drv = stop_ok;
    wait_clks(stop_ok ? 104 : 65);
    rx_drv = 1'b1;
    wait_clks(stop_ok ? 0 : 104);
  endtask
  task automatic get_tx_byte(output logic [7:0] b, output logic ok);
    int n = 0;
    b = 8'h00;
    ok = 1'b0;
    while (tx !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (tx === 1'b0) begin
      wait_clks(52);
      ok = tx === 1'b0;
      for (int i = 0; i < 8; i++) begin
        wait_clks(104);
        b[i] = tx;
      end
      wait_clks(104);
      ok = ok & (tx === 1'b1);
    end
  endtask
  task automatic wait_rx(output logic ok);
    int n = 0;
    while (rx_empty !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    ok = rx_empty === 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b0;
    wait_clks(5);
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b expected 1", tx); end
    tests++; if (rx_empty !== 1'b1) begin fails++; $display("FAIL reset_rx_empty: got %b expected 1", rx_empty); end
    tests++; if (rx_full !== 1'b0) begin fails++; $display("FAIL reset_rx_full: got %b expected 0", rx_full); end
    tests++; if (tx_full !== 1'b0) begin fails++; $display("FAIL reset_tx_full: got %b expected 0", tx_full); end
    tests++; if (rx_frame_error !== 1'b0) begin fails++; $display("FAIL reset_frame_error: got %b expected 0", rx_frame_error); end
    tests++; if (read_data !== 8'h00) begin fails++; $display("FAIL reset_read_data: got %h expected 00", read_data); end
    reset = 1'b1;
    wait_clks(5);
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL idle_tx: got %b expected 1", tx); end
  endtask
  task automatic test_loopback();
    logic [7:0] exp [3];
    logic ok;
    exp[0] = 8'h55;
    exp[1] = 8'hA3;
    exp[2] = 8'h00;
    loop = 1'b1;
    for (int i = 0; i < 3; i++) push(exp[i]);
    for (int i = 0; i < 3; i++) begin
      wait_rx(ok);
      tests++; if (!ok) begin fails++; $display("FAIL loopback_wait%0d: got rx_empty=%b expected 0 within 3000 clk", i, rx_empty); end
      pop();
      tests++; if (read_data !== exp[i]) begin fails++; $display("FAIL loopback_data%0d: got %h expected %h", i, read_data, exp[i]); end
    end
    tests++; if (rx_empty !== 1'b1) begin fails++; $display("FAIL loopback_empty: got %b expected 1", rx_empty); end
    wait_clks(10);
    loop = 1'b0;
  endtask
  task automatic test_frame_error();
    int hi = 0;
    fork
      send_frame(8'hC1, 1'b0);
      for (int i = 0; i < 2000; i++) begin
        @(negedge clk);
        if (rx_frame_error === 1'b1) hi++;
      end
    join
    tests++; if (hi != 1) begin fails++; $display("FAIL frame_error_pulse: got %0d high cycles expected 1", hi); end
    tests++; if (rx_empty !== 1'b1) begin fails++; $display("FAIL frame_error_empty: got %b expected 1", rx_empty); end
  endtask
  task automatic test_tx_full();
    logic [7:0] got [17];
    logic okv [17];
    int low = 0;
    fork
      begin
        push(8'hA0);
        wait_clks(30);
        for (int i = 1; i < 16; i++) push(8'hA0 + 8'(i));
        tests++; if (tx_full !== 1'b0) begin fails++; $display("FAIL tx_full_15: got %b expected 0", tx_full); end
        push(8'hB0);
        tests++; if (tx_full !== 1'b1) begin fails++; $display("FAIL tx_full_16: got %b expected 1", tx_full); end
        push(8'hEE);
        tests++; if (tx_full !== 1'b1) begin fails++; $display("FAIL tx_full_extra: got %b expected 1", tx_full); end
      end
      for (int i = 0; i < 17; i++) get_tx_byte(got[i], okv[i]);
    join
    for (int i = 0; i < 17; i++) begin
      tests++;
      if (!okv[i] || got[i] !== 8'hA0 + 8'(i)) begin
        fails++;
        $display("FAIL tx_order%0d: got %h (framing ok=%b) expected %h", i, got[i], okv[i], 8'hA0 + 8'(i));
      end
    end
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (tx === 1'b0) low++;
    end
    tests++; if (low != 0) begin fails++; $display("FAIL tx_extra_dropped: got %0d low cycles expected 0", low); end
  endtask
  task automatic test_rx_full();
    for (int i = 0; i < 17; i++) send_frame(8'h30 + 8'(i), 1'b1);
    wait_clks(10);
    tests++; if (rx_full !== 1'b1) begin fails++; $display("FAIL rx_full_set: got %b expected 1", rx_full); end
    for (int i = 0; i < 16; i++) begin
      pop();
      tests++; if (read_data !== 8'h30 + 8'(i)) begin fails++; $display("FAIL rx_order%0d: got %h expected %h", i, read_data, 8'h30 + 8'(i)); end
      if (i == 0) begin
        tests++; if (rx_full !== 1'b0) begin fails++; $display("FAIL rx_full_clear: got %b expected 0", rx_full); end
      end
    end
    tests++; if (rx_empty !== 1'b1) begin fails++; $display("FAIL rx_17th_dropped: got rx_empty=%b expected 1", rx_empty); end
  endtask
  task automatic test_glitch();
    int hi = 0;
    rx_drv = 1'b0;
    wait_clks(20);
    rx_drv = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rx_frame_error === 1'b1) hi++;
    end
    tests++; if (hi != 0) begin fails++; $display("FAIL glitch_no_error: got %0d high cycles expected 0", hi); end
    tests++; if (rx_empty !== 1'b1) begin fails++; $display("FAIL glitch_no_byte: got rx_empty=%b expected 1", rx_empty); end
    pop();
    tests++; if (read_data !== 8'h3F) begin fails++; $display("FAIL read_empty_hold: got %h expected 3F", read_data); end
    tests++; if (rx_empty !== 1'b1) begin fails++; $display("FAIL read_empty_flag: got %b expected 1", rx_empty); end
  endtask
  task automatic test_reset_midframe();
    int n = 0;
    int low = 0;
    push(8'h00);
    while (tx !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests++; if (tx !== 1'b0) begin fails++; $display("FAIL midframe_start: got %b expected 0", tx); end
    wait_clks(200);
    #2 reset = 1'b0;
    #1;
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL midframe_async_tx: got %b expected 1", tx); end
    wait_clks(2);
    reset = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (tx === 1'b0) low++;
    end
    tests++; if (low != 0) begin fails++; $display("FAIL midframe_aborted: got %0d low cycles expected 0", low); end
  endtask
  initial begin
    test_reset();
    test_loopback();
    test_frame_error();
    test_tx_full();
    test_rx_full();
    test_glitch();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
